mm_sequencer: RTL and testbench
===============================

// Module: mm_sequencer
// PURPOSE
//  Sequences one C = A x B matrix multiply over the mm_defs datapath: walks (i,j,k),
//  issues A/B operand reads, drives MAC clear/enable, writes each C element.
//  Sits between the testbench or host start/done interface, the operand memories and the MAC unit.
//  One output element per pass, no overlap between elements.
// PARAMETERS
//  M_DIM   2  rows of A and C
//  N_DIM   2  cols of A = rows of B (inner/reduction dimension)
//  P_DIM   2  cols of B and C
//  RD_LAT  1  operand memory read latency in cycles (>=1)
// PORTS
//  clk        in   1                   system clock, all logic on posedge
//  rst        in   1                   synchronous, active-high reset
//  start      in   1                   begin multiply; sampled only in IDLE
//  busy       out  1                   high in every state except IDLE
//  done       out  1                   one-cycle pulse, DONE state
//  a_rd_en    out  1                   A read strobe
//  a_rd_addr  out  $clog2(M_DIM*N_DIM) A address = i*N_DIM+k
//  b_rd_en    out  1                   B read strobe (always equals a_rd_en)
//  b_rd_addr  out  $clog2(N_DIM*P_DIM) B address = k*P_DIM+j
//  mac_clr    out  1                   clear accumulator; coincident with first mac_en of each element
//  mac_en     out  1                   accumulate; a_rd_en delayed RD_LAT cycles
//  c_wr_en    out  1                   C write request, held until accepted
//  c_wr_addr  out  $clog2(M_DIM*P_DIM) C address = i*P_DIM+j
//  c_wr_ready in   1                   C write accepted when c_wr_en & c_wr_ready
// BEHAVIOUR
//  - Reset: state=IDLE, i=j=k=0, delay line cleared, every output 0. Reset wins over every other input.
//  - All outputs registered. Addresses are 0 whenever their strobe is low.
//  - FSM:
//    - IDLE -> ISSUE on start.
//    - ISSUE: one A/B read per cycle, k=0..N_DIM-1; after k=N_DIM-1 go to DRAIN, k<=0.
//    - DRAIN: RD_LAT cycles, no new reads, mac_en still drains -> WRITE.
//    - WRITE: c_wr_en=1, addr stable until c_wr_ready.
//      On accept: last element (i=M_DIM-1, j=P_DIM-1) -> DONE, else advance and -> ISSUE.
//    - DONE: done=1 for one cycle -> IDLE.
//  - Element order is row-major: j increments first and wraps P_DIM-1 -> 0 with i+1; i wraps to 0 at end.
//  - mac_clr=1 on the mac_en cycle carrying k=0 (pipelined alongside mac_en).
//  - Cost per element: N_DIM + RD_LAT + 1 cycles, plus cycles with c_wr_ready low in WRITE.
//  - start while busy (including the DONE cycle) is ignored, not queued. start and rst together: rst wins.
//  - rst mid-operation: IDLE next cycle; in-flight mac_en/mac_clr discarded; no partial C write.
//  - N_DIM=1: ISSUE lasts one cycle, mac_en and mac_clr coincide.
// CONFIGURATION
//  - MM_PERF_CNT_EN defined: adds ports perf_cycles[31:0] and perf_stalls[31:0] (out).
//    - Both clear on accepted start.
//    - perf_cycles counts cycles in ISSUE/DRAIN/WRITE.
//    - perf_stalls counts WRITE cycles with c_wr_ready=0.
//    - Both saturate at 32'hFFFF_FFFF, hold after DONE, reset to 0.
//  - MM_PERF_CNT_EN undefined: ports and counters absent, no other behaviour change.
// TESTING (defaults M=N=P=2, RD_LAT=1, c_wr_ready=1 unless stated; start sampled at cycle 0)
//  1. Reset held 3 cycles, then released with start=0 -> all outputs 0, busy=0, stays IDLE.
//  2. Single start pulse ->
//     - element (0,0): a_rd_addr 0,1 and b_rd_addr 0,2 in cycles 1-2; mac_en cycles 2-3; mac_clr cycle 2.
//     - c_wr_addr sequence 0,1,2,3 in cycles 4,8,12,16.
//     - done=1 cycle 17 only; busy cycles 1-17.
//  3. c_wr_ready=0 for 3 cycles at first WRITE -> c_wr_en held, c_wr_addr=0 stable; done moves to cycle 20.
//  4. start re-pulsed at cycles 5 and 17 -> both ignored; a start at cycle 18 (IDLE) begins a fresh run.
//  5. rst at cycle 6 (mid-ISSUE) -> cycle 7 all outputs 0; a new start replays the full sequence from c_wr_addr 0.
//  6. MM_PERF_CNT_EN defined, run of test 3 -> perf_cycles=19, perf_stalls=3 after done; both 0 after next start.

Source files
------------

// File: rtl/mm_sequencer.sv
// Sequencer for one C = A x B matrix multiply: walks (i,j,k), issues operand reads,
// drives MAC clear/enable and writes each C element. Optional perf counters: MM_PERF_CNT_EN.
module mm_sequencer #(
  parameter int M_DIM  = 2,
  parameter int N_DIM  = 2,
  parameter int P_DIM  = 2,
  parameter int RD_LAT = 1,
  localparam int A_AW = (M_DIM * N_DIM > 1) ? $clog2(M_DIM * N_DIM) : 1,
  localparam int B_AW = (N_DIM * P_DIM > 1) ? $clog2(N_DIM * P_DIM) : 1,
  localparam int C_AW = (M_DIM * P_DIM > 1) ? $clog2(M_DIM * P_DIM) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            a_rd_en,
  output logic [A_AW-1:0] a_rd_addr,
  output logic            b_rd_en,
  output logic [B_AW-1:0] b_rd_addr,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            c_wr_en,
  output logic [C_AW-1:0] c_wr_addr,
  input  logic            c_wr_ready
`ifdef MM_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls
`endif
);

  localparam int IW = (M_DIM > 1) ? $clog2(M_DIM) : 1;
  localparam int JW = (P_DIM > 1) ? $clog2(P_DIM) : 1;
  localparam int KW = (N_DIM > 1) ? $clog2(N_DIM) : 1;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     i, ni;
  logic [JW-1:0]     j, nj;
  logic [KW-1:0]     k;
  logic [DW-1:0]     drain_cnt;
  logic              last_i, last_j;
  logic              rd_first;
  logic [RD_LAT-1:0] en_pipe;
  logic [RD_LAT-1:0] clr_pipe;

  function automatic logic [A_AW-1:0] a_addr(input logic [IW-1:0] ii, input logic [KW-1:0] kk);
    return A_AW'(int'(ii) * N_DIM + int'(kk));
  endfunction

  function automatic logic [B_AW-1:0] b_addr(input logic [KW-1:0] kk, input logic [JW-1:0] jj);
    return B_AW'(int'(kk) * P_DIM + int'(jj));
  endfunction

  function automatic logic [C_AW-1:0] c_addr(input logic [IW-1:0] ii, input logic [JW-1:0] jj);
    return C_AW'(int'(ii) * P_DIM + int'(jj));
  endfunction

  always_comb begin
    last_i = (i == IW'(M_DIM - 1));
    last_j = (j == JW'(P_DIM - 1));
    nj     = last_j ? '0 : j + 1'b1;
    ni     = i;
    if (last_j) ni = last_i ? '0 : i + 1'b1;
  end

  assign b_rd_en = a_rd_en;
  assign mac_en  = en_pipe[RD_LAT-1];
  assign mac_clr = clr_pipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      drain_cnt <= '0;
      rd_first  <= 1'b0;
      en_pipe   <= '0;
      clr_pipe  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_rd_en   <= 1'b0;
      a_rd_addr <= '0;
      b_rd_addr <= '0;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
    end else begin
      // mac_en/mac_clr are the read strobe and its k=0 tag delayed by the memory latency
      en_pipe[0]  <= a_rd_en;
      clr_pipe[0] <= rd_first;
      for (int unsigned n = 1; n < RD_LAT; n++) begin
        en_pipe[n]  <= en_pipe[n-1];
        clr_pipe[n] <= clr_pipe[n-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            k         <= '0;
            a_rd_en   <= 1'b1;
            a_rd_addr <= a_addr(i, '0);
            b_rd_addr <= b_addr('0, j);
            rd_first  <= 1'b1;
          end
        end
        ISSUE: begin
          rd_first <= 1'b0;
          if (k == KW'(N_DIM - 1)) begin
            state     <= DRAIN;
            k         <= '0;
            drain_cnt <= '0;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
          end else begin
            k         <= k + 1'b1;
            a_rd_addr <= a_addr(i, k + 1'b1);
            b_rd_addr <= b_addr(k + 1'b1, j);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(RD_LAT - 1)) begin
            state     <= WRITE;
            c_wr_en   <= 1'b1;
            c_wr_addr <= c_addr(i, j);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (c_wr_ready) begin
            c_wr_en   <= 1'b0;
            c_wr_addr <= '0;
            i         <= ni;
            j         <= nj;
            if (last_i && last_j) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              a_rd_en   <= 1'b1;
              a_rd_addr <= a_addr(ni, '0);
              b_rd_addr <= b_addr('0, nj);
              rd_first  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if ((state == ISSUE || state == DRAIN || state == WRITE) && perf_cycles != '1)
        perf_cycles <= perf_cycles + 1'b1;
      if (state == WRITE && !c_wr_ready && perf_stalls != '1)
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer (M=N=P=2, RD_LAT=1): per-cycle vector table plus
// hand sequences for write back-pressure, perf counters and reset/start collisions.
module tb_mm_sequencer;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       c_wr_ready = 1'b1;
  logic       busy, done, a_rd_en, b_rd_en, mac_clr, mac_en, c_wr_en;
  logic [1:0] a_rd_addr, b_rd_addr, c_wr_addr;
`ifdef MM_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_sequencer #(.M_DIM(2), .N_DIM(2), .P_DIM(2), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .a_rd_en    (a_rd_en),
    .a_rd_addr  (a_rd_addr),
    .b_rd_en    (b_rd_en),
    .b_rd_addr  (b_rd_addr),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .c_wr_en    (c_wr_en),
    .c_wr_addr  (c_wr_addr),
    .c_wr_ready (c_wr_ready)
`ifdef MM_PERF_CNT_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
`endif
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       a_en;
    logic [1:0] a_addr;
    logic [1:0] b_addr;
    logic       mac_en;
    logic       mac_clr;
    logic       c_en;
    logic [1:0] c_addr;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  start;
    logic  rdy;
    logic  chk;
    outs_t exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t g[0:18];
  outs_t zero;

  function automatic outs_t mk(int b, int d, int ae, int aa, int ba, int me, int mc, int ce, int ca);
    outs_t o;
    o.busy    = 1'(b);
    o.done    = 1'(d);
    o.a_en    = 1'(ae);
    o.a_addr  = 2'(aa);
    o.b_addr  = 2'(ba);
    o.mac_en  = 1'(me);
    o.mac_clr = 1'(mc);
    o.c_en    = 1'(ce);
    o.c_addr  = 2'(ca);
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.busy    = busy;
    o.done    = done;
    o.a_en    = a_rd_en;
    o.a_addr  = a_rd_addr;
    o.b_addr  = b_rd_addr;
    o.mac_en  = mac_en;
    o.mac_clr = mac_clr;
    o.c_en    = c_wr_en;
    o.c_addr  = c_wr_addr;
    return o;
  endfunction

  task automatic push(input logic r, input logic s, input logic rd, input logic c, input outs_t e);
    vec_t v;
    v.rst = r; v.start = s; v.rdy = rd; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Golden single-run trace, cycle 0 = start sampled:
    //        busy done a_en a   b  mac clr c_en c
    g[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    g[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
    g[2]  = mk(1, 0, 1, 1, 2, 1, 1, 0, 0);
    g[3]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    g[4]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
    g[5]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);
    g[6]  = mk(1, 0, 1, 1, 3, 1, 1, 0, 0);
    g[7]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    g[8]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1);
    g[9]  = mk(1, 0, 1, 2, 0, 0, 0, 0, 0);
    g[10] = mk(1, 0, 1, 3, 2, 1, 1, 0, 0);
    g[11] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    g[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 2);
    g[13] = mk(1, 0, 1, 2, 1, 0, 0, 0, 0);
    g[14] = mk(1, 0, 1, 3, 3, 1, 1, 0, 0);
    g[15] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    g[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 3);
    g[17] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    g[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero  = g[0];

    // Reset held 3 cycles, then idle with start low
    push(1, 0, 1, 0, zero);
    push(1, 0, 1, 1, zero);
    push(1, 0, 1, 1, zero);
    push(0, 0, 1, 1, zero);
    push(0, 0, 1, 1, zero);
    // Full run; starts at 5 and 17 are ignored, start at 18 begins a fresh run
    for (int t = 0; t <= 18; t++)
      push(0, (t == 0 || t == 5 || t == 17 || t == 18), 1, 1, g[t]);
    // Fresh run aborted by rst during its cycle 6
    for (int t = 19; t <= 24; t++)
      push(t == 24, 0, 1, 1, g[t - 18]);
    push(0, 0, 1, 1, zero);
    // New start replays the whole sequence from element 0
    push(0, 1, 1, 1, zero);
    for (int t = 27; t <= 44; t++)
      push(0, 0, 1, 1, g[t - 26]);

    foreach (vecs[r]) begin
      @(negedge clk);
      if (vecs[r].chk) begin
        outs_t act;
        act = sample();
        checks++;
        if (act !== vecs[r].exp || b_rd_en !== vecs[r].exp.a_en) begin
          errors++;
          $display("FAIL vec[%0d]: got {busy,done,a_en,a,b,mac,clr,c_en,c}=%b b_en=%b expected %b",
                   r, act, b_rd_en, vecs[r].exp);
        end
      end
      rst        = vecs[r].rst;
      start      = vecs[r].start;
      c_wr_ready = vecs[r].rdy;
    end

    // Back-pressure at the first WRITE, then perf readout and clear on next start
    for (int t = 0; t <= 23; t++) begin
      @(negedge clk);
      if (t >= 4 && t <= 7) begin
        check("bp_c_wr_en", t, 32'(c_wr_en), 32'd1);
        check("bp_c_wr_addr", t, 32'(c_wr_addr), 32'd0);
      end
      if (t == 8) begin
        check("bp_release_c_wr_en", t, 32'(c_wr_en), 32'd0);
        check("bp_next_a_addr", t, {30'd0, a_rd_addr}, 32'd0);
        check("bp_next_b_addr", t, {30'd0, b_rd_addr}, 32'd1);
      end
      if (t >= 19 && t <= 21)
        check("bp_done", t, 32'(done), (t == 20) ? 32'd1 : 32'd0);
      if (t == 21) begin
        check("bp_busy_after_done", t, 32'(busy), 32'd0);
`ifdef MM_PERF_CNT_EN
        check("perf_cycles", t, perf_cycles, 32'd19);
        check("perf_stalls", t, perf_stalls, 32'd3);
`endif
      end
      if (t == 23) begin
        check("restart_busy", t, 32'(busy), 32'd1);
`ifdef MM_PERF_CNT_EN
        check("perf_cycles_clr", t, perf_cycles, 32'd0);
        check("perf_stalls_clr", t, perf_stalls, 32'd0);
`endif
      end
      start      = (t == 0 || t == 22);
      c_wr_ready = !(t >= 4 && t <= 6);
    end

    // rst together with start mid-run: reset wins, start is not queued
    @(negedge clk);
    check("pre_rst_mac_en", 24, 32'(mac_en), 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 25, 32'(busy), 32'd0);
    check("rst_start_mac_en", 25, 32'(mac_en), 32'd0);
    check("rst_start_a_en", 25, 32'(a_rd_en), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", 26, 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
